// File: rtl/vote_pkg.sv
// Shared definitions for the vote_tally block: session FSM state encoding.
package vote_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OPEN = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/vote_ballot_reg.sv
// Voted bitmap: flags out-of-range or duplicate ballots and reports when every voter has voted.
module vote_ballot_reg #(
   parameter int unsigned N_VOTERS = 3,
   parameter int unsigned IDW      = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           clear,
   input  logic           check,
   input  logic [IDW-1:0] vote_id,
   output logic           accept,
   output logic           reject,
   output logic           all_voted
);

   logic [N_VOTERS-1:0] voted_q;
   logic [N_VOTERS-1:0] voted_d;
   logic [N_VOTERS-1:0] hit;
   logic [N_VOTERS-1:0] set_mask;

   // One-hot decode; an out-of-range ID leaves hit all-zero.
   for (genvar g = 0; g < N_VOTERS; g++) begin : g_hit
      assign hit[g] = (32'(vote_id) == 32'(g));
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no latch can be inferred.
      accept    = 1'b0;
      reject    = 1'b0;
      set_mask  = '0;
      voted_d   = voted_q;
      if (check) begin
         accept = (|hit) && !(|(hit & voted_q));
         reject = !accept;
      end
      if (accept) set_mask = hit;
      all_voted = &(voted_q | set_mask);
      if (clear) voted_d = '0;
      else       voted_d = voted_q | set_mask;
   end

   // NOTE: the bitmap is control state, not a data array, so it is reset with the FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) voted_q <= '0;
      else       voted_q <= voted_d;
   end

endmodule

// File: rtl/vote_tally.sv
// Voting session controller: opens on start, tallies one ballot per voter, holds the majority decision.
module vote_tally
   import vote_pkg::*;
#(
   parameter int unsigned N_VOTERS = 3,
   parameter int unsigned IDW      = 2,
   parameter int unsigned CW       = 2
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           start,
   input  logic           vote_valid,
   input  logic [IDW-1:0] vote_id,
   input  logic           vote_val,
   input  logic           close,
   output logic           open,
   output logic [CW-1:0]  yes_cnt,
   output logic [CW-1:0]  no_cnt,
   output logic           result_valid,
   output logic           result,
   output logic           tie,
   output logic           err
);

   localparam logic [CW:0] N_CMP = (CW+1)'(N_VOTERS);

   state_e        state_q;
   logic [CW-1:0] yes_q, no_q;
   logic [CW-1:0] yes_d, no_d;
   logic          result_q, tie_q, err_q;
   logic          in_open, clear;
   logic          accept, reject, all_voted;
   logic [CW:0]   twice_yes;

   assign in_open = (state_q == OPEN);
   assign clear   = start && !in_open;

   vote_ballot_reg #(
      .N_VOTERS (N_VOTERS),
      .IDW      (IDW)
   ) u_ballot (
      .clk       (clk),
      .reset     (reset),
      .clear     (clear),
      .check     (vote_valid && in_open),
      .vote_id   (vote_id),
      .accept    (accept),
      .reject    (reject),
      .all_voted (all_voted)
   );

   assign yes_d = yes_q + CW'(accept && vote_val);
   assign no_d  = no_q  + CW'(accept && !vote_val);

   // Doubling in CW+1 bits cannot overflow, and the decision sees the vote accepted on the closing edge.
   assign twice_yes = {yes_d, 1'b0};

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         yes_q    <= '0;
         no_q     <= '0;
         result_q <= 1'b0;
         tie_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         err_q <= reject;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q  <= OPEN;
                  yes_q    <= '0;
                  no_q     <= '0;
                  result_q <= 1'b0;
                  tie_q    <= 1'b0;
               end
            end
            OPEN: begin
               yes_q <= yes_d;
               no_q  <= no_d;
               if (all_voted || close) begin
                  state_q  <= DONE;
                  result_q <= (twice_yes > N_CMP);
                  tie_q    <= (twice_yes == N_CMP);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign open         = in_open;
   assign result_valid = (state_q == DONE);
   assign yes_cnt      = yes_q;
   assign no_cnt       = no_q;
   assign result       = result_q;
   assign tie          = tie_q;
   assign err          = err_q;

endmodule
